// File: rtl/pulse_ext_pkg.sv
// rtl/pulse_ext_pkg.sv - shared state encoding and sizing helper for the pulse extender
package pulse_ext_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pe_state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_ext_multi_if.sv
// rtl/pulse_ext_multi_if.sv - per-channel event, acknowledge and status bundle
interface pulse_ext_multi_if #(
    parameter int CH_NUM = 4
);
    logic [CH_NUM-1:0] src_pulse;
    logic [CH_NUM-1:0] dst_ack;
    logic [CH_NUM-1:0] ovf_clr;
    logic [CH_NUM-1:0] ext_pulse;
    logic [CH_NUM-1:0] busy;
    logic [CH_NUM-1:0] ovf;

    modport master (
        output src_pulse, dst_ack, ovf_clr,
        input  ext_pulse, busy, ovf
    );

    modport slave (
        input  src_pulse, dst_ack, ovf_clr,
        output ext_pulse, busy, ovf
    );
endinterface

// File: rtl/pulse_ext_ch.sv
// rtl/pulse_ext_ch.sv - one channel: IDLE/HIGH/LOW pacing FSM, timer, pending counter, overflow flag
module pulse_ext_ch
    import pulse_ext_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int ACK_MODE = 0,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pulse,
    input  logic i_ack,
    input  logic i_ovf_clr,
    output logic o_ext,
    output logic o_busy,
    output logic o_ovf
);
    localparam int TMR_W = $clog2(max(HOLD_CYC, GAP_CYC) + 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    pe_state_t        r_state, w_state_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [CNT_W-1:0] r_pend, w_pend_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_hi_done, w_lo_done, w_launch, w_drop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_hi_done   = (ACK_MODE != 0) ? i_ack  : (r_tmr == '0);
        w_lo_done   = (ACK_MODE != 0) ? !i_ack : (r_tmr == '0);
        // A LOW phase that has run out chains straight into the next launch.
        w_launch    = ((r_state == ST_IDLE) || (r_state == ST_LOW && w_lo_done))
                      && ((r_pend != '0) || i_pulse);
        w_drop      = i_pulse && !w_launch && (r_pend == PEND_MAX);
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        if (w_launch) begin
            w_state_nxt = ST_HIGH;
            w_tmr_nxt   = HOLD_LD;
        end else begin
            case (r_state)
                ST_HIGH: begin
                    if (w_hi_done) begin
                        w_state_nxt = ST_LOW;
                        w_tmr_nxt   = GAP_LD;
                    end else if (ACK_MODE == 0) begin
                        w_tmr_nxt = r_tmr - TMR_W'(1);
                    end
                end
                ST_LOW: begin
                    if (w_lo_done) begin
                        w_state_nxt = ST_IDLE;
                        w_tmr_nxt   = '0;
                    end else if (ACK_MODE == 0) begin
                        w_tmr_nxt = r_tmr - TMR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        case ({i_pulse, w_launch})
            2'b10:   w_pend_nxt = w_drop ? r_pend : r_pend + CNT_W'(1);
            2'b01:   w_pend_nxt = r_pend - CNT_W'(1);
            default: w_pend_nxt = r_pend;
        endcase
        w_ovf_nxt  = w_drop || (r_ovf && !i_ovf_clr);
        w_busy_nxt = (w_state_nxt != ST_IDLE) || (w_pend_nxt != '0);
    end

    always_comb begin
        o_ext  = (r_state == ST_HIGH);
        o_busy = r_busy;
        o_ovf  = r_ovf;
    end

endmodule

// File: rtl/pulse_ext_multi.sv
// rtl/pulse_ext_multi.sv - CH_NUM independent pulse extender/queuer channels
module pulse_ext_multi
    import pulse_ext_pkg::*;
#(
    parameter int CH_NUM   = 4,
    parameter int CNT_W    = 4,
    parameter int ACK_MODE = 0,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4
) (
    input  logic             src_clk,
    input  logic             src_rst,
    pulse_ext_multi_if.slave bus
);
    logic [CH_NUM-1:0] w_ext;
    logic [CH_NUM-1:0] w_busy;
    logic [CH_NUM-1:0] w_ovf;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        pulse_ext_ch #(
            .CNT_W    (CNT_W),
            .ACK_MODE (ACK_MODE),
            .HOLD_CYC (HOLD_CYC),
            .GAP_CYC  (GAP_CYC)
        ) u_ch (
            .i_clk     (src_clk),
            .i_rst     (src_rst),
            .i_pulse   (bus.src_pulse[g]),
            .i_ack     (bus.dst_ack[g]),
            .i_ovf_clr (bus.ovf_clr[g]),
            .o_ext     (w_ext[g]),
            .o_busy    (w_busy[g]),
            .o_ovf     (w_ovf[g])
        );
    end

    assign bus.ext_pulse = w_ext;
    assign bus.busy      = w_busy;
    assign bus.ovf       = w_ovf;

endmodule

// File: tb/tb_pulse_ext_multi.sv
// tb/tb_pulse_ext_multi.sv - bench for pulse_ext_multi in timed and handshake configurations
module tb_pulse_ext_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pulse = '0;
    logic [3:0] ack = '0;
    logic [3:0] clr = '0;
    int         cyc = 0;
    int         t0 = 0;
    int         checks = 0;
    int         errors = 0;
    bit         cmp_en = 1'b0;

    always #5 clk = ~clk;

    // instance 0: timed 2/2, instance 1: handshake, instance 2: timed 3/5 with two channels
    localparam int P_HOLD [3] = '{2, 2, 3};
    localparam int P_GAP  [3] = '{2, 2, 5};
    localparam int P_MODE [3] = '{0, 1, 0};
    localparam int P_MAX  [3] = '{3, 3, 15};
    localparam int P_NCH  [3] = '{4, 4, 2};

    pulse_ext_multi_if #(.CH_NUM(4)) if_t ();
    pulse_ext_multi_if #(.CH_NUM(4)) if_a ();
    pulse_ext_multi_if #(.CH_NUM(2)) if_d ();

    assign if_t.src_pulse = pulse;      assign if_t.dst_ack = ack;      assign if_t.ovf_clr = clr;
    assign if_a.src_pulse = pulse;      assign if_a.dst_ack = ack;      assign if_a.ovf_clr = clr;
    assign if_d.src_pulse = pulse[1:0]; assign if_d.dst_ack = ack[1:0]; assign if_d.ovf_clr = clr[1:0];

    pulse_ext_multi #(.CH_NUM(4), .CNT_W(2), .ACK_MODE(0), .HOLD_CYC(2), .GAP_CYC(2))
        u_t (.src_clk(clk), .src_rst(rst), .bus(if_t));
    pulse_ext_multi #(.CH_NUM(4), .CNT_W(2), .ACK_MODE(1), .HOLD_CYC(2), .GAP_CYC(2))
        u_a (.src_clk(clk), .src_rst(rst), .bus(if_a));
    pulse_ext_multi #(.CH_NUM(2), .CNT_W(4), .ACK_MODE(0), .HOLD_CYC(3), .GAP_CYC(5))
        u_d (.src_clk(clk), .src_rst(rst), .bus(if_d));

    logic [3:0] ext_o [3];
    logic [3:0] busy_o [3];
    logic [3:0] ovf_o [3];
    assign ext_o[0] = if_t.ext_pulse;  assign busy_o[0] = if_t.busy;  assign ovf_o[0] = if_t.ovf;
    assign ext_o[1] = if_a.ext_pulse;  assign busy_o[1] = if_a.busy;  assign ovf_o[1] = if_a.ovf;
    assign ext_o[2] = {2'b00, if_d.ext_pulse};
    assign busy_o[2] = {2'b00, if_d.busy};
    assign ovf_o[2] = {2'b00, if_d.ovf};

    // Timed channels are described by the cycle of their latest rising edge;
    // handshake channels by whether they await ack high or ack low.
    int m_rise [3][4];
    int m_p    [3][4];
    bit m_ovf  [3][4];
    bit m_hi   [3][4];
    bit m_lo   [3][4];

    function automatic bit exp_ext(input int k, input int ch);
        if (P_MODE[k] != 0) return m_hi[k][ch];
        return (m_rise[k][ch] <= cyc) && (cyc < m_rise[k][ch] + P_HOLD[k]);
    endfunction

    function automatic bit exp_busy(input int k, input int ch);
        if (P_MODE[k] != 0) return m_hi[k][ch] || m_lo[k][ch] || (m_p[k][ch] != 0);
        return (cyc < m_rise[k][ch] + P_HOLD[k] + P_GAP[k]) || (m_p[k][ch] != 0);
    endfunction

    task automatic model_step();
        bit pu, ak, free, launch, drop;
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < P_NCH[k]; ch++) begin
                if (rst) begin
                    m_rise[k][ch] = -1000; m_p[k][ch] = 0; m_ovf[k][ch] = 0;
                    m_hi[k][ch] = 0; m_lo[k][ch] = 0;
                end else begin
                    pu = pulse[ch];
                    ak = ack[ch];
                    if (P_MODE[k] == 0)
                        free = (cyc + 1 >= m_rise[k][ch] + P_HOLD[k] + P_GAP[k]);
                    else
                        free = (!m_hi[k][ch] && !m_lo[k][ch]) || (m_lo[k][ch] && !ak);
                    launch = free && (m_p[k][ch] > 0 || pu);
                    drop = pu && !launch && (m_p[k][ch] == P_MAX[k]);
                    if (P_MODE[k] == 0) begin
                        if (launch) m_rise[k][ch] = cyc + 1;
                    end else if (launch) begin
                        m_hi[k][ch] = 1; m_lo[k][ch] = 0;
                    end else if (m_hi[k][ch] && ak) begin
                        m_hi[k][ch] = 0; m_lo[k][ch] = 1;
                    end else if (m_lo[k][ch] && !ak) begin
                        m_lo[k][ch] = 0;
                    end
                    if (!drop) m_p[k][ch] = m_p[k][ch] + int'(pu) - int'(launch);
                    m_ovf[k][ch] = drop || (m_ovf[k][ch] && !clr[ch]);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] ee, eb, eo;
        for (int k = 0; k < 3; k++) begin
            ee = '0; eb = '0; eo = '0;
            for (int ch = 0; ch < P_NCH[k]; ch++) begin
                ee[ch] = exp_ext(k, ch);
                eb[ch] = exp_busy(k, ch);
                eo[ch] = m_ovf[k][ch];
            end
            checks += 3;
            if (ext_o[k] !== ee) begin
                errors++;
                $display("FAIL ext inst%0d cyc=%0d got=%b want=%b", k, cyc - t0, ext_o[k], ee);
            end
            if (busy_o[k] !== eb) begin
                errors++;
                $display("FAIL busy inst%0d cyc=%0d got=%b want=%b", k, cyc - t0, busy_o[k], eb);
            end
            if (ovf_o[k] !== eo) begin
                errors++;
                $display("FAIL ovf inst%0d cyc=%0d got=%b want=%b", k, cyc - t0, ovf_o[k], eo);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (cmp_en) compare_all();
    endtask

    task automatic go(input int rel);
        while (cyc - t0 < rel) tick();
    endtask

    task automatic scn_reset();
        rst = 1'b1;
        pulse = '0; ack = '0; clr = '0;
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        t0 = cyc;
    endtask

    // which: 0 = ext_pulse, 1 = busy, 2 = ovf; checks both the DUT and the model
    task automatic pin(input string nm, input int k, input int ch, input int which, input bit exp);
        logic a;
        bit   m;
        case (which)
            0:       begin a = ext_o[k][ch];  m = exp_ext(k, ch);  end
            1:       begin a = busy_o[k][ch]; m = exp_busy(k, ch); end
            default: begin a = ovf_o[k][ch];  m = m_ovf[k][ch];    end
        endcase
        checks += 2;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s dut got=%b want=%b", nm, a, exp);
        end
        if (m !== exp) begin
            errors++;
            $display("FAIL %s model got=%b want=%b", nm, m, exp);
        end
    endtask

    initial begin
        // single event
        scn_reset();
        pin("reset_ext", 0, 0, 0, 1'b0);
        pin("reset_busy", 0, 0, 1, 1'b0);
        pin("reset_ovf", 0, 0, 2, 1'b0);
        go(10); pulse = 4'b0001;
        go(11); pulse = 4'b0000;
        pin("t1_ext11", 0, 0, 0, 1'b1);
        go(12); pin("t1_ext12", 0, 0, 0, 1'b1);
        go(13); pin("t1_ext13", 0, 0, 0, 1'b0);
        pin("d1_ext13", 2, 0, 0, 1'b1);
        go(14); pin("t1_busy14", 0, 0, 1, 1'b1);
        pin("d1_ext14", 2, 0, 0, 1'b0);
        go(15); pin("t1_busy15", 0, 0, 1, 1'b0);
        go(18); pin("d1_busy18", 2, 0, 1, 1'b1);
        go(19); pin("d1_busy19", 2, 0, 1, 1'b0);
        go(20); pin("a1_hold20", 1, 0, 0, 1'b1);
        go(30);

        // three queued events on channels 0 and 3
        scn_reset();
        go(10); pulse = 4'b1001;
        go(13); pulse = 4'b0000;
        go(15); pin("t2_ext15", 0, 0, 0, 1'b1);
        go(17); pin("t2_ext17", 0, 0, 0, 1'b0);
        go(19); pin("t2_ext19", 0, 0, 0, 1'b1);
        pin("t2_ch3_19", 0, 3, 0, 1'b1);
        pin("t2_ch1_19", 0, 1, 0, 1'b0);
        pin("t2_ch2_19", 0, 2, 0, 1'b0);
        go(20); pin("t2_ext20", 0, 0, 0, 1'b1);
        go(21); pin("t2_ext21", 0, 0, 0, 1'b0);
        go(22); pin("t2_busy22", 0, 0, 1, 1'b1);
        go(23); pin("t2_busy23", 0, 3, 1, 1'b0);
        go(40);

        // saturation and overflow clear
        scn_reset();
        go(10); pulse = 4'b0001;
        go(17); pulse = 4'b0000;
        pin("t3_ovf17", 0, 0, 2, 1'b1);
        pin("d3_ovf17", 2, 0, 2, 1'b0);
        go(19); pulse = 4'b0001;
        go(20); clr = 4'b0001;
        go(21); pulse = 4'b0000; clr = 4'b0000;
        pin("t3_ovf_setwins", 0, 0, 2, 1'b1);
        go(22); clr = 4'b0001;
        go(23); clr = 4'b0000;
        pin("t3_ovf_cleared", 0, 0, 2, 1'b0);
        go(34); pin("t3_busy34", 0, 0, 1, 1'b1);
        go(35); pin("t3_busy35", 0, 0, 1, 1'b0);
        go(40);

        // handshake pacing
        scn_reset();
        go(5); pulse = 4'b0001;
        go(6); pulse = 4'b0000;
        pin("a4_ext6", 1, 0, 0, 1'b1);
        go(7); pulse = 4'b0001;
        go(8); pulse = 4'b0000;
        go(9); ack = 4'b0001;
        pin("a4_ext9", 1, 0, 0, 1'b1);
        go(10); pin("a4_ext10", 1, 0, 0, 1'b0);
        go(12); pin("a4_busy12", 1, 0, 1, 1'b1);
        go(14); ack = 4'b0000;
        pin("a4_ext14", 1, 0, 0, 1'b0);
        go(15); pin("a4_ext15", 1, 0, 0, 1'b1);
        go(20); ack = 4'b0001;
        go(24); ack = 4'b0000;
        go(30); pin("a4_busy30", 1, 0, 1, 1'b0);

        // reset while HIGH with events queued
        scn_reset();
        go(6); pulse = 4'b1111;
        go(12); pulse = 4'b0000;
        pin("t5_ext12", 0, 3, 0, 1'b1);
        pin("t5_ovf12", 0, 2, 2, 1'b1);
        rst = 1'b1;
        go(13); rst = 1'b0;
        pin("t5_ext13", 0, 0, 0, 1'b0);
        pin("t5_busy13", 0, 0, 1, 1'b0);
        pin("t5_ovf13", 0, 2, 2, 1'b0);
        pin("d5_ext13", 2, 0, 0, 1'b0);
        go(30);
        pin("t5_busy30", 0, 3, 1, 1'b0);
        pin("t5_ext30", 0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
